// File: rtl/axis_even_pad_pkg.sv
// Shared types and defaults for the even-length AXI-Stream padder.
package axis_even_pad_pkg;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_PAD  = 1'b1
  } state_t;

  localparam logic [31:0] PAD_WORD_DEF  = 32'h0000_0000;
  localparam int          CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/axis_even_pad.sv
// Appends one pad word to odd-length AXI-Stream packets so TLAST always lands on an even word.
// One-cycle registered latency; S_AXIS_TREADY follows the output slot and drops for the pad cycle.
module axis_even_pad
  import axis_even_pad_pkg::*;
#(
  parameter logic [31:0] PAD_WORD  = PAD_WORD_DEF,
  parameter int          CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 AXIS_ACLK,
  input  logic                 AXIS_ARESET,
  input  logic [31:0]          S_AXIS_TDATA,
  input  logic                 S_AXIS_TVALID,
  input  logic                 S_AXIS_TLAST,
  output logic                 S_AXIS_TREADY,
  output logic [31:0]          M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  output logic                 M_AXIS_TLAST,
  input  logic                 M_AXIS_TREADY,
  output logic [CNT_WIDTH-1:0] PAD_COUNT
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_odd;
  logic [31:0]          r_tdata;
  logic                 r_tlast;
  logic                 r_tvalid;
  logic [CNT_WIDTH-1:0] r_pad_count;
  logic                 w_tready;
  logic                 w_s_xfr;
  logic                 w_m_xfr;
  logic                 w_odd_close;
  logic                 w_pad_load;

  assign w_s_xfr     = S_AXIS_TVALID & w_tready;
  assign w_m_xfr     = r_tvalid & M_AXIS_TREADY;
  // r_odd=0 before a TLAST beat means that beat makes the packet length odd.
  assign w_odd_close = w_s_xfr & S_AXIS_TLAST & ~r_odd;
  assign w_pad_load  = (r_state == ST_PAD) & w_m_xfr;

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      r_state <= ST_PASS;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_PASS: if (w_odd_close) w_state_nxt = ST_PAD;
      ST_PAD:  if (w_m_xfr)     w_state_nxt = ST_PASS;
    endcase
  end

  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      ST_PASS: w_tready = ~r_tvalid | M_AXIS_TREADY;
      ST_PAD:  w_tready = 1'b0;
    endcase
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      r_odd <= 1'b0;
    end else if (w_s_xfr) begin
      r_odd <= S_AXIS_TLAST ? 1'b0 : ~r_odd;
    end
  end

  // Pad enters the slot on the same edge the odd packet's final data beat leaves.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      r_tdata  <= 32'h0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_s_xfr) begin
      r_tdata  <= S_AXIS_TDATA;
      r_tlast  <= S_AXIS_TLAST & r_odd;
      r_tvalid <= 1'b1;
    end else if (w_pad_load) begin
      r_tdata  <= PAD_WORD;
      r_tlast  <= 1'b1;
      r_tvalid <= 1'b1;
    end else if (w_m_xfr) begin
      r_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      r_pad_count <= '0;
    end else if (w_pad_load && (r_pad_count != CNT_MAX)) begin
      r_pad_count <= r_pad_count + 1'b1;
    end
  end

  assign S_AXIS_TREADY = w_tready;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TLAST  = r_tlast;
  assign PAD_COUNT     = r_pad_count;

endmodule

// File: tb/tb_axis_even_pad.sv
// Bench for axis_even_pad: two instances (default and DEADBEEF/2-bit counter) driven in lockstep.
module tb_axis_even_pad;

  localparam logic [31:0] PADW1 = 32'hDEAD_BEEF;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        p;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_dat;
  logic        s_vld, s_lst, m_rdy;
  logic        s_rdy0, s_rdy1;
  logic [31:0] m_dat0, m_dat1;
  logic        m_vld0, m_vld1, m_lst0, m_lst1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  always #5 clk = ~clk;

  axis_even_pad u_dut0 (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_dat), .S_AXIS_TVALID(s_vld), .S_AXIS_TLAST(s_lst), .S_AXIS_TREADY(s_rdy0),
    .M_AXIS_TDATA(m_dat0), .M_AXIS_TVALID(m_vld0), .M_AXIS_TLAST(m_lst0), .M_AXIS_TREADY(m_rdy),
    .PAD_COUNT(cnt0)
  );

  axis_even_pad #(.PAD_WORD(PADW1), .CNT_WIDTH(2)) u_dut1 (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .S_AXIS_TDATA(s_dat), .S_AXIS_TVALID(s_vld), .S_AXIS_TLAST(s_lst), .S_AXIS_TREADY(s_rdy1),
    .M_AXIS_TDATA(m_dat1), .M_AXIS_TVALID(m_vld1), .M_AXIS_TLAST(m_lst1), .M_AXIS_TREADY(m_rdy),
    .PAD_COUNT(cnt1)
  );

  int n_chk = 0;
  int n_pass = 0;

  beat_t       in_q[$];
  beat_t       exp_q[$];
  int          n_odd = 0;
  int          n_in_stall;
  bit          hold;
  bit          pad_pending;
  int          in_cnt;
  int          out_cnt;
  int          stall_left = 0;
  logic [31:0] stall_dat = 32'h0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic sv, input logic [31:0] sd, input logic sl, input logic mr);
    s_vld = sv;
    s_dat = sd;
    s_lst = sl;
    m_rdy = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream: payload words in order, last on the final word of even packets,
  // otherwise one pad word carrying last.
  task automatic push_pkt(input int len, input logic [31:0] base, input bit rnd);
    logic [31:0] d;
    for (int i = 0; i < len; i++) begin
      d = rnd ? $urandom : base + i;
      in_q.push_back('{d: d, l: (i == len - 1), p: 1'b0});
      exp_q.push_back('{d: d, l: (i == len - 1) && (len % 2 == 0), p: 1'b0});
    end
    if (len % 2 == 1) begin
      exp_q.push_back('{d: 32'h0, l: 1'b1, p: 1'b1});
      n_odd++;
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic clear_model();
    in_q.delete();
    exp_q.delete();
    hold = 0;
    pad_pending = 0;
    in_cnt = 0;
    out_cnt = 0;
    n_odd = 0;
  endtask

  task automatic run(input int vpct, input int rpct, input int max_cyc, output int cyc);
    beat_t       h, e;
    bit          sv, mr, sx, mx, stl;
    logic [31:0] sd0, sd1;
    logic        sl0, sl1;
    cyc = 0;
    n_in_stall = 0;
    forever begin
      if (in_q.size() == 0 && exp_q.size() == 0 && !m_vld0) break;
      if (cyc >= max_cyc) begin
        chk("drain_timeout", in_q.size() + exp_q.size(), 0);
        break;
      end
      sv = hold || (in_q.size() > 0 && $urandom_range(99) < vpct);
      mr = ($urandom_range(99) < rpct);
      if (stall_left > 0 && m_vld0 && m_dat0 == stall_dat) begin
        mr = 1'b0;
        stall_left--;
      end
      h = (in_q.size() > 0) ? in_q[0] : '0;
      drive(sv, h.d, h.l, mr);
      #1;
      sx = sv && s_rdy0;
      mx = m_vld0 && mr;
      if (sv && !s_rdy0) n_in_stall++;
      if (mx) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", m_vld0, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dat0", m_dat0, e.p ? 32'h0 : e.d);
          chk("lst0", m_lst0, e.l);
          chk("vld1", m_vld1, 1);
          chk("dat1", m_dat1, e.p ? PADW1 : e.d);
          chk("lst1", m_lst1, e.l);
        end
        out_cnt++;
        if (m_lst0) begin
          chk("even_len", out_cnt % 2, 0);
          out_cnt = 0;
        end
      end
      if (sx) chk("acc_in_pad", pad_pending, 0);
      if (mx && pad_pending) pad_pending = 0;
      if (sx) begin
        in_cnt++;
        if (h.l) begin
          if (in_cnt % 2 == 1) pad_pending = 1;
          in_cnt = 0;
        end
        void'(in_q.pop_front());
      end
      hold = sv && !sx;
      stl = m_vld0 && !mr;
      sd0 = m_dat0; sl0 = m_lst0; sd1 = m_dat1; sl1 = m_lst1;
      tick();
      cyc++;
      if (stl) begin
        chk("hold_vld", m_vld0, 1);
        chk("hold_dat0", m_dat0, sd0);
        chk("hold_lst0", m_lst0, sl0);
        chk("hold_dat1", m_dat1, sd1);
        chk("hold_lst1", m_lst1, sl1);
      end
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    drive(0, 32'h0, 0, 0);
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_vld", m_vld0, 0);
    chk("rst_lst", m_lst0, 0);
    chk("rst_dat", m_dat0, 32'h0);
    chk("rst_cnt", cnt0, 0);
    chk("rst_rdy", s_rdy0, 1);

    // 4-word packet, full throughput
    push_pkt(4, 32'hA000_0000, 0);
    run(100, 100, 50, cyc);
    chk("a_cycles", cyc, 5);
    chk("a_in_stall", n_in_stall, 0);
    chk("a_cnt", cnt0, 0);

    // 3-word then 2-word back to back
    push_pkt(3, 32'hB000_0000, 0);
    push_pkt(2, 32'hC000_0000, 0);
    run(100, 100, 50, cyc);
    chk("bc_cycles", cyc, 7);
    chk("bc_in_stall", n_in_stall, 1);
    chk("bc_cnt", cnt0, 1);

    // single-word packet
    push_pkt(1, 32'hD000_0000, 0);
    run(100, 100, 50, cyc);
    chk("d_cycles", cyc, 3);
    chk("d_cnt1", cnt1, 2);

    // 5-word packet, downstream stalls 3 cycles on the last data word, another packet waiting
    push_pkt(5, 32'hE000_0000, 0);
    push_pkt(2, 32'hF100_0000, 0);
    stall_dat = 32'hE000_0004;
    stall_left = 3;
    run(100, 100, 50, cyc);
    chk("e_cycles", cyc, 12);
    chk("e_cnt0", cnt0, 3);
    chk("e_cnt1", cnt1, 3);

    // fourth pad: 2-bit counter must stay saturated
    push_pkt(1, 32'h5A00_0000, 0);
    run(100, 100, 50, cyc);
    chk("sat_cnt0", cnt0, 4);
    chk("sat_cnt1", cnt1, 3);

    // reset while in the pad state
    drive(1, 32'hF000_0000, 0, 1); tick();
    drive(1, 32'hF000_0001, 0, 1); tick();
    drive(1, 32'hF000_0002, 1, 1); tick();
    drive(0, 32'h0, 0, 0);
    #1;
    chk("pad_rdy", s_rdy0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("prst_vld0", m_vld0, 0);
    chk("prst_vld1", m_vld1, 0);
    chk("prst_lst", m_lst0, 0);
    chk("prst_dat", m_dat0, 32'h0);
    chk("prst_cnt0", cnt0, 0);
    chk("prst_cnt1", cnt1, 0);
    chk("prst_rdy", s_rdy0, 1);
    clear_model();
    push_pkt(2, 32'h1200_0000, 0);
    run(100, 100, 50, cyc);
    chk("prst_cycles", cyc, 3);
    chk("prst_cnt_after", cnt0, 0);

    // random traffic
    for (int i = 0; i < 1000; i++) push_pkt($urandom_range(16, 1), 32'h0, 1);
    run(70, 70, 80000, cyc);
    chk("rnd_cnt0", cnt0, n_odd);
    chk("rnd_cnt1", cnt1, sat3(n_odd));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
